ps2_kbd_tx: RTL and testbench

Device-side PS/2 keyboard transmitter: the keyboard end of the link whose host end samples ps2_clk falling edges.
- Accepts scan codes over a valid/ready interface into a small FIFO.
- Optionally prefixes a code with the break byte 0xF0.
- Generates ps2_clk and ps2_data frames (start, 8 data LSB-first, odd parity, stop).
- Used as an on-board keyboard emulator and as the stimulus source for host-receiver verification.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_kbd_tx_if.sv | 23 ++
 rtl/ps2_tx_fifo.sv | 53 +++++
 rtl/ps2_kbd_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, FSM states, FIFO entry.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HI,
    LO,
    GAP
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  function automatic logic ps2_odd_parity(
    input logic [7:0] b
  );
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Scan-code valid/ready handshake into the keyboard transmitter.
interface ps2_kbd_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       in_brk;

  modport master (
    output in_valid,
    output in_code,
    output in_brk,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  in_brk,
    output in_ready
  );

endinterface

// File: rtl/ps2_tx_fifo.sv
// Small FIFO for PS/2 bytes; extra pointer bit separates full/empty.
module ps2_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: FIFO of scan codes,
// optional 0xF0 break prefix, 11-bit frames on ps2_clk/ps2_data.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  ps2_kbd_tx_if.slave     in_if,
  output logic            ps2_clk,
  output logic            ps2_data,
  output logic            busy,
  output logic            frame_done
);

  localparam int MAXC =
    (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e  state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] shreg_q, shreg_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  code_q, code_d;
  logic        pend_q, pend_d;
  logic        frame_done_q, frame_done_d;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [8:0]  rdata;
  ps2_entry_t  head;

  assign in_if.in_ready = ~rst & ~full;
  assign push = in_if.in_valid & in_if.in_ready;
  assign head = rdata;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_if.in_brk, in_if.in_code}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_d       = byte_q;
    code_d       = code_q;
    pend_d       = pend_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
          if (head.brk) begin
            byte_d = PS2_BREAK;
            pend_d = 1'b1;
            code_d = head.code;
          end else begin
            byte_d = head.code;
          end
        end
      end
      LOAD: begin
        shreg_d = {1'b1, ps2_odd_parity(byte_q),
                   byte_q, 1'b0};
        bit_cnt_d = '0;
        phase_d   = '0;
        state_d   = HI;
      end
      HI: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          state_d = LO;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      LO: begin
        if (phase_q == DIV_LAST) begin
          phase_d   = '0;
          shreg_d   = {1'b1, shreg_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d      = GAP;
            frame_done_d = 1'b1;
          end else begin
            state_d = HI;
          end
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          if (pend_q) begin
            pend_d  = 1'b0;
            byte_d  = code_q;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '1;
      byte_q       <= '0;
      code_q       <= '0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_q       <= byte_d;
      code_q       <= code_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // shreg only moves on LO exit, so data is frozen while clk is low
  assign ps2_clk    = (state_q != LO);
  assign ps2_data   = (state_q == HI || state_q == LO) ?
                      shreg_q[0] : 1'b1;
  assign busy       = (state_q != IDLE) | ~empty;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: directed + random pushes, frame-level
// reference model, line-timing monitor, host-receiver loopback.
module tb_ps2_kbd_tx;

  localparam int DIV = 4;
  localparam int GAP = 8;
  localparam int DIV50 = 50;
  localparam int GAP50 = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ps2_kbd_tx_if if1 ();
  ps2_kbd_tx_if if50 ();

  logic ps2_clk, ps2_data, busy, frame_done;
  logic ps2_clk50, ps2_data50, busy50, frame_done50;

  ps2_kbd_tx #(
    .CLK_DIV(DIV), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .in_if(if1.slave),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .frame_done(frame_done)
  );

  ps2_kbd_tx #(
    .CLK_DIV(DIV50), .GAP_CYCLES(GAP50), .FIFO_DEPTH(4)
  ) u_dut50 (
    .clk(clk), .rst(rst), .in_if(if50.slave),
    .ps2_clk(ps2_clk50), .ps2_data(ps2_data50),
    .busy(busy50), .frame_done(frame_done50)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Expected wire image of one byte, as seen edge by edge
  function automatic logic [10:0] frame_of(
    input logic [7:0] b
  );
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ($countones(b) % 2) == 0;
    f[10]  = 1'b1;
    return f;
  endfunction

  logic [7:0]  exp_q[$];
  logic [10:0] flog[$];
  int          n_frames = 0;
  int          nbits = 0;
  int          lo_cnt = 0;
  logic        prev_clk = 1'b1;
  logic        held = 1'b1;
  logic [10:0] cur = '0;

  // Samples the line like a host: one bit per falling edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      nbits = 0;
      lo_cnt = 0;
      prev_clk = 1'b1;
    end else begin
      if (!ps2_clk) begin
        if (prev_clk) begin
          if (nbits < 11) cur[nbits] = ps2_data;
          nbits++;
          held = ps2_data;
        end else begin
          check("data_stable", ps2_data, held);
        end
        lo_cnt++;
      end else if (!prev_clk) begin
        check("lo_len", lo_cnt, DIV);
        lo_cnt = 0;
      end
      if (frame_done) begin
        check("frame_bits", nbits, 11);
        flog.push_back(cur);
        n_frames++;
        if (exp_q.size() > 0)
          check("frame", cur, frame_of(exp_q.pop_front()));
        else
          check("unexpected_frame", 1, 0);
        nbits = 0;
      end
      prev_clk = ps2_clk;
    end
  end

  logic [2:0]  s_clk = 3'b111;
  logic [2:0]  s_dat = 3'b111;
  logic [10:0] rx_bits = '0;
  int          rx_n = 0;
  logic [7:0]  rx_q[$];

  // Host receiver: 3-flop sync, sample on synced falling edge
  always @(posedge clk) begin
    #1;
    s_clk = {s_clk[1:0], ps2_clk50};
    s_dat = {s_dat[1:0], ps2_data50};
    if (s_clk[2] && !s_clk[1]) begin
      rx_bits[rx_n] = s_dat[1];
      rx_n++;
      if (rx_n == 11) begin
        check("rx_start", rx_bits[0], 0);
        check("rx_stop", rx_bits[10], 1);
        check("rx_parity", $countones(rx_bits[9:1]) % 2, 1);
        rx_q.push_back(rx_bits[8:1]);
        rx_n = 0;
      end
    end
  end

  task automatic push1(input logic [7:0] c, input logic b);
    int n;
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.in_code = c;
    if1.in_brk = b;
    n = 0;
    while (!if1.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", n < 2000, 1);
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    if (b) exp_q.push_back(8'hF0);
    exp_q.push_back(c);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 5000);
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int k, m, f0, acc, n;
    logic r;
    logic [7:0] codes[6];
    logic [8:0] ent[3];
    logic [7:0] exp50[4];

    if1.in_valid = 0; if1.in_code = 0; if1.in_brk = 0;
    if50.in_valid = 0; if50.in_code = 0; if50.in_brk = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", if1.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", if1.in_ready, 1);

    // single make code, exact latency to frame_done and idle
    push1(8'h1C, 1'b0);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!frame_done && k < 300);
    check("fd_latency", k, 2 + 22 * DIV);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
    end while (busy && m < 300);
    check("gap_len", m, GAP);
    check("frame_1c", flog[$], 11'h438);
    check("n_frames_1", n_frames, 1);

    // break code: two frames
    f0 = n_frames;
    push1(8'h1C, 1'b1);
    wait_idle();
    check("n_frames_brk", n_frames - f0, 2);
    check("frame_f0", flog[$-1], 11'h7E0);
    check("frame_1c_b", flog[$], 11'h438);

    // back-to-back pushes fill the FIFO
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.in_code = codes[0];
    if1.in_brk = 1'b0;
    acc = 0;
    n = 0;
    while (acc < 6 && n < 3000) begin
      r = if1.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (r) begin
        exp_q.push_back(codes[acc]);
        acc++;
        if (acc == 5) check("ready_full", if1.in_ready, 0);
        if (acc < 6) if1.in_code = codes[acc];
      end
      @(negedge clk);
    end
    if1.in_valid = 1'b0;
    check("accepted6", acc, 6);
    wait_idle();
    check("fifo_drained", exp_q.size(), 0);

    // random codes and break flags
    for (int i = 0; i < 10; i++) begin
      push1(8'($urandom_range(0, 255)),
            $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_idle();
    check("rand_drained", exp_q.size(), 0);

    // reset during the low phase of bit 5
    push1(8'h5A, 1'b0);
    push1(8'h33, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(nbits == 6 && !ps2_clk) && n < 500);
    check("reach_bit5", nbits, 6);
    f0 = n_frames;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_clk", ps2_clk, 1);
    check("mid_rst_data", ps2_data, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fd", frame_done, 0);
    check("mid_rst_ready", if1.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_idle", busy, 0);
    check("mid_rst_noframe", n_frames, f0);
    push1(8'hA7, 1'b0);
    wait_idle();
    check("after_rst_frame", n_frames, f0 + 1);
    check("after_rst_drained", exp_q.size(), 0);

    // loopback at CLK_DIV=50 into host receiver
    ent = '{{1'b0, 8'h1C}, {1'b1, 8'h1C}, {1'b0, 8'h45}};
    exp50 = '{8'h1C, 8'hF0, 8'h1C, 8'h45};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if50.in_valid = 1'b1;
      {if50.in_brk, if50.in_code} = ent[i];
      n = 0;
      while (!if50.in_ready && n < 20000) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      if50.in_valid = 1'b0;
    end
    n = 0;
    while (rx_q.size() < 4 && n < 8000) begin
      @(posedge clk);
      n++;
    end
    check("rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size())
        check("rx_byte", rx_q[i], exp50[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
